// File: rtl/bidir_dir_ctrl.sv
// Direction controller for a half-duplex a<->b buffer. It arbitrates between the two
// sides, inserts turnaround dead cycles and preempts a holder that exceeds its hold budget.
module bidir_dir_ctrl #(
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_ab,
  input  logic last_ab,
  input  logic req_ba,
  input  logic last_ba,
  output logic gnt_ab,
  output logic gnt_ba,
  output logic cntrl,
  output logic en_ab,
  output logic en_ba,
  output logic busy,
  output logic preempt
);

  typedef enum logic [1:0] {StIdle, StDrvAb, StDrvBa, StTurn} state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] TurnLast = CNT_W'(TURN_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] turn_q, turn_d;
  logic             tgt_q, tgt_d;  // 1: TURN is heading towards a->b
  logic             win_q, win_d;  // 1: a->b was the most recent grant
  logic             cntrl_q, cntrl_d;
  logic             preempt_d;
  logic             gnt_ab_q, gnt_ba_q, busy_q, preempt_q;

  logic want_ab, holder_ab, own_req, own_last, other_req, tgt_req;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    tgt_d     = tgt_q;
    win_d     = win_q;
    cntrl_d   = cntrl_q;
    preempt_d = 1'b0;
    want_ab   = (req_ab && req_ba) ? !win_q : req_ab;
    holder_ab = (state_q == StDrvAb);
    own_req   = holder_ab ? req_ab  : req_ba;
    own_last  = holder_ab ? last_ab : last_ba;
    other_req = holder_ab ? req_ba  : req_ab;
    tgt_req   = tgt_q ? req_ab : req_ba;

    unique case (state_q)
      StIdle: begin
        if (req_ab || req_ba) begin
          if (want_ab == cntrl_q) begin
            state_d = want_ab ? StDrvAb : StDrvBa;
            hold_d  = '0;
            win_d   = want_ab;
          end else begin
            state_d = StTurn;
            turn_d  = '0;
            tgt_d   = want_ab;
          end
        end
      end
      StDrvAb, StDrvBa: begin
        if (!own_req || own_last) begin
          if (other_req) begin
            state_d = StTurn;
            turn_d  = '0;
            tgt_d   = !holder_ab;
          end else begin
            state_d = StIdle;
          end
        end else if (other_req && hold_q >= HoldLast) begin
          state_d   = StTurn;
          turn_d    = '0;
          tgt_d     = !holder_ab;
          preempt_d = 1'b1;
        end else if (hold_q < HoldLast) begin
          hold_d = hold_q + 1'b1;
        end
      end
      StTurn: begin
        if (turn_q >= TurnLast) begin
          // Direction flips even if the target has gone away, leaving the bus parked there.
          cntrl_d = tgt_q;
          if (tgt_req) begin
            state_d = tgt_q ? StDrvAb : StDrvBa;
            hold_d  = '0;
            win_d   = tgt_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      turn_q    <= '0;
      tgt_q     <= 1'b0;
      win_q     <= 1'b0;
      cntrl_q   <= 1'b0;
      gnt_ab_q  <= 1'b0;
      gnt_ba_q  <= 1'b0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
      tgt_q     <= tgt_d;
      win_q     <= win_d;
      cntrl_q   <= cntrl_d;
      gnt_ab_q  <= (state_d == StDrvAb);
      gnt_ba_q  <= (state_d == StDrvBa);
      busy_q    <= (state_d != StIdle);
      preempt_q <= preempt_d;
    end
  end

  assign gnt_ab  = gnt_ab_q;
  assign gnt_ba  = gnt_ba_q;
  assign en_ab   = gnt_ab_q;
  assign en_ba   = gnt_ba_q;
  assign cntrl   = cntrl_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule
